// File: rtl/change_dispense_sequencer.sv
// Coin payout sequencer: pays a change amount through a req/ack coin hopper,
// always taking the largest coin that fits and is in stock.
module change_dispense_sequencer #(
   parameter int DEN_HI      = 10,
   parameter int DEN_MID     = 5,
   parameter int DEN_LO      = 1,
   parameter int STOCK_W     = 6,
   parameter int INIT_STOCK  = 20,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [7:0]         change_in,
   input  logic               hopper_ack,
   input  logic               refill,
   input  logic [1:0]         refill_sel,
   input  logic [STOCK_W-1:0] refill_cnt,
   output logic               hopper_req,
   output logic [1:0]         hopper_sel,
   output logic               busy,
   output logic               done,
   output logic               fault,
   output logic [7:0]         remaining,
   output logic [STOCK_W-1:0] stock_hi,
   output logic [STOCK_W-1:0] stock_mid,
   output logic [STOCK_W-1:0] stock_lo
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SELECT = 3'd1;
   localparam logic [2:0] S_REQ    = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;
   localparam logic [2:0] S_FAULT  = 3'd4;

   localparam logic [1:0] SEL_HI  = 2'd0;
   localparam logic [1:0] SEL_MID = 2'd1;
   localparam logic [1:0] SEL_LO  = 2'd2;

   localparam logic [7:0] VAL_HI  = 8'(DEN_HI);
   localparam logic [7:0] VAL_MID = 8'(DEN_MID);
   localparam logic [7:0] VAL_LO  = 8'(DEN_LO);

   localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

   localparam int             TW         = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0]  TIMER_LAST = TW'(ACK_TIMEOUT - 1);

   logic [2:0]    state;
   logic [TW-1:0] timer;
   logic          hi_ok;
   logic          mid_ok;
   logic          lo_ok;
   logic          refill_ok;
   logic [7:0]    sel_val;

   function automatic logic [STOCK_W-1:0] sat_add(input logic [STOCK_W-1:0] a,
                                                   input logic [STOCK_W-1:0] b);
      logic [STOCK_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[STOCK_W] ? {STOCK_W{1'b1}} : sum[STOCK_W-1:0];
   endfunction

   // A coin qualifies only if it cannot overshoot the amount, so remaining never wraps.
   assign hi_ok     = (VAL_HI  <= remaining) && (stock_hi  != '0);
   assign mid_ok    = (VAL_MID <= remaining) && (stock_mid != '0);
   assign lo_ok     = (VAL_LO  <= remaining) && (stock_lo  != '0);
   assign refill_ok = (state == S_IDLE) && refill && (refill_sel != 2'd3);

   always_comb begin
      sel_val = VAL_LO;
      case (hopper_sel)
         SEL_HI:  sel_val = VAL_HI;
         SEL_MID: sel_val = VAL_MID;
         default: sel_val = VAL_LO;
      endcase
   end

   assign hopper_req = (state == S_REQ);
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);

   // Refills only land in IDLE and decrements only in REQ, so they never collide.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         hopper_sel <= SEL_HI;
         fault      <= 1'b0;
         remaining  <= '0;
         timer      <= '0;
         stock_hi   <= STOCK_INIT;
         stock_mid  <= STOCK_INIT;
         stock_lo   <= STOCK_INIT;
      end else begin
         if (refill_ok) begin
            case (refill_sel)
               SEL_HI:  stock_hi  <= sat_add(stock_hi,  refill_cnt);
               SEL_MID: stock_mid <= sat_add(stock_mid, refill_cnt);
               default: stock_lo  <= sat_add(stock_lo,  refill_cnt);
            endcase
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  remaining <= change_in;
                  fault     <= 1'b0;
                  state     <= S_SELECT;
               end
            end
            S_SELECT: begin
               timer <= '0;
               if (remaining == '0) begin
                  state <= S_DONE;
               end else if (hi_ok) begin
                  hopper_sel <= SEL_HI;
                  state      <= S_REQ;
               end else if (mid_ok) begin
                  hopper_sel <= SEL_MID;
                  state      <= S_REQ;
               end else if (lo_ok) begin
                  hopper_sel <= SEL_LO;
                  state      <= S_REQ;
               end else begin
                  state <= S_FAULT;
               end
            end
            S_REQ: begin
               if (hopper_ack) begin
                  case (hopper_sel)
                     SEL_HI:  stock_hi  <= stock_hi  - 1'b1;
                     SEL_MID: stock_mid <= stock_mid - 1'b1;
                     default: stock_lo  <= stock_lo  - 1'b1;
                  endcase
                  remaining <= remaining - sel_val;
                  state     <= S_SELECT;
               end else if (timer == TIMER_LAST) begin
                  state <= S_FAULT;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            S_FAULT: begin
               fault <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispense_sequencer.sv
// Scoreboard bench for change_dispense_sequencer: a greedy payout model queues
// the expected coin codes, which are popped as the hopper requests appear.
module tb_change_dispense_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] change_in;
   logic       hopper_ack;
   logic       refill;
   logic [1:0] refill_sel;
   logic [5:0] refill_cnt;
   logic       hopper_req;
   logic [1:0] hopper_sel;
   logic       busy;
   logic       done;
   logic       fault;
   logic [7:0] remaining;
   logic [5:0] stock_hi;
   logic [5:0] stock_mid;
   logic [5:0] stock_lo;

   int checks   = 0;
   int failures = 0;

   int ms[3];
   int vals[3] = '{10, 5, 1};
   logic [1:0] exp_q[$];

   int last_done_cyc;
   int last_busy_cnt;
   int last_req_total;

   change_dispense_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .change_in  (change_in),
      .hopper_ack (hopper_ack),
      .refill     (refill),
      .refill_sel (refill_sel),
      .refill_cnt (refill_cnt),
      .hopper_req (hopper_req),
      .hopper_sel (hopper_sel),
      .busy       (busy),
      .done       (done),
      .fault      (fault),
      .remaining  (remaining),
      .stock_hi   (stock_hi),
      .stock_mid  (stock_mid),
      .stock_lo   (stock_lo)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   task automatic checkStocks(input string tag);
      checkOutput({tag, "_stock_hi"},  32'(stock_hi),  32'(ms[0]));
      checkOutput({tag, "_stock_mid"}, 32'(stock_mid), 32'(ms[1]));
      checkOutput({tag, "_stock_lo"},  32'(stock_lo),  32'(ms[2]));
   endtask

   task automatic doRefill(input int sel, input int cnt);
      @(negedge clk);
      refill     = 1'b1;
      refill_sel = 2'(sel);
      refill_cnt = 6'(cnt);
      @(negedge clk);
      refill = 1'b0;
      if (sel != 3) ms[sel] = (ms[sel] + cnt > 63) ? 63 : ms[sel] + cnt;
   endtask

   // One payout: model the greedy choice, start the DUT, play hopper, then compare.
   task automatic applyStimulus(input int amt, input bit ack_on, input bit refill_busy, input string tag);
      int  rem;
      int  pick;
      bit  exp_fault;
      bit  finished;
      int  req_run;
      int  done_cnt;
      rem       = amt;
      exp_fault = 1'b0;
      exp_q.delete();
      while (rem != 0) begin
         pick = -1;
         for (int d = 0; d < 3; d++)
            if (pick < 0 && vals[d] <= rem && ms[d] != 0) pick = d;
         if (pick < 0) begin
            exp_fault = 1'b1;
            break;
         end
         exp_q.push_back(2'(pick));
         if (!ack_on) begin
            exp_fault = 1'b1;
            break;
         end
         ms[pick]--;
         rem -= vals[pick];
      end

      finished       = 1'b0;
      req_run        = 0;
      done_cnt       = 0;
      last_done_cyc  = 0;
      last_busy_cnt  = 0;
      last_req_total = 0;
      @(negedge clk);
      start     = 1'b1;
      change_in = 8'(amt);
      for (int cyc = 1; cyc <= 1000 && !finished; cyc++) begin
         @(negedge clk);
         if (cyc == 1) start = 1'b0;
         if (refill_busy && cyc == 3) begin
            refill     = 1'b1;
            refill_sel = 2'd0;
            refill_cnt = 6'd7;
         end
         if (cyc == 4) refill = 1'b0;
         if (busy) last_busy_cnt++;
         if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
         end
         if (hopper_req) begin
            last_req_total++;
            req_run++;
            if (req_run == 1) begin
               if (exp_q.size() == 0) checkOutput({tag, "_extra_req"}, 1, 0);
               else checkOutput({tag, "_sel"}, 32'(hopper_sel), 32'(exp_q.pop_front()));
            end
            hopper_ack = ack_on && (req_run == 2);
         end else begin
            req_run    = 0;
            hopper_ack = 1'b0;
         end
         if (!busy) finished = 1'b1;
      end
      hopper_ack = 1'b0;
      if (!finished) checkOutput({tag, "_timeout"}, 1, 0);
      checkOutput({tag, "_coins_left"}, 32'(exp_q.size()), 0);
      checkOutput({tag, "_done_cnt"}, 32'(done_cnt), exp_fault ? 0 : 1);
      checkOutput({tag, "_fault"}, 32'(fault), 32'(exp_fault));
      checkOutput({tag, "_remaining"}, 32'(remaining), 32'(rem));
      checkOutput({tag, "_req_idle"}, 32'(hopper_req), 0);
      checkStocks(tag);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      change_in  = 8'd0;
      hopper_ack = 1'b0;
      refill     = 1'b0;
      refill_sel = 2'd0;
      refill_cnt = 6'd0;
      for (int d = 0; d < 3; d++) ms[d] = 20;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_req", 32'(hopper_req), 0);
      checkOutput("rst_sel", 32'(hopper_sel), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_fault", 32'(fault), 0);
      checkOutput("rst_remaining", 32'(remaining), 0);
      checkStocks("rst");

      applyStimulus(17, 1'b1, 1'b0, "pay17");
      checkOutput("pay17_lo_final", 32'(stock_lo), 18);

      applyStimulus(0, 1'b1, 1'b0, "zero");
      checkOutput("zero_done_cyc", 32'(last_done_cyc), 2);
      checkOutput("zero_busy_cnt", 32'(last_busy_cnt), 2);
      checkOutput("zero_req_cnt", 32'(last_req_total), 0);

      while (ms[0] > 0) applyStimulus(10, 1'b1, 1'b0, "drain_hi");
      applyStimulus(10, 1'b1, 1'b0, "mid_pair");
      checkOutput("mid_pair_stock", 32'(stock_mid), 17);

      applyStimulus(85, 1'b1, 1'b0, "drain_mid");
      applyStimulus(18, 1'b1, 1'b0, "drain_lo");
      applyStimulus(3, 1'b1, 1'b0, "no_coins");
      checkOutput("no_coins_req_cnt", 32'(last_req_total), 0);
      applyStimulus(0, 1'b1, 1'b0, "fault_clear");

      doRefill(1, 20);
      doRefill(2, 20);
      checkStocks("refill");
      applyStimulus(5, 1'b0, 1'b0, "ack_timeout");
      checkOutput("ack_timeout_req_cycles", 32'(last_req_total), 255);
      checkOutput("ack_timeout_mid", 32'(stock_mid), 20);

      doRefill(2, 50);
      checkOutput("refill_sat_lo", 32'(stock_lo), 63);
      doRefill(3, 9);
      doRefill(0, 5);
      checkStocks("refill_sel3");

      applyStimulus(5, 1'b1, 1'b1, "busy_refill");

      @(negedge clk);
      start     = 1'b1;
      change_in = 8'd17;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("mid_req_active", 32'(hopper_req), 1);
      reset = 1'b1;
      for (int d = 0; d < 3; d++) ms[d] = 20;
      @(negedge clk);
      checkOutput("mid_rst_req", 32'(hopper_req), 0);
      checkOutput("mid_rst_busy", 32'(busy), 0);
      checkStocks("mid_rst");
      reset = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_busy", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
